pwm_seq_ctrl: RTL and testbench

Duty-cycle sequencer placed between the Wishbone register bank and `pwm_core`, running in the PWM clock domain (Sys_Clk1). It ramps the PWM duty from its current value to a programmed target in fixed increments. Each increment is paced by a programmable number of PWM period boundaries, so software can request soft-start, soft-stop or fades with one register write instead of a CPU-timed loop.

---
 rtl/pwm_seq_pkg.sv | 40 ++++
 rtl/pwm_seq_ctrl_if.sv | 40 ++++
 rtl/pwm_seq_tick.sv | 40 ++++
 rtl/pwm_seq_ctrl.sv | 104 ++++++++++
 tb/tb_pwm_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types, default widths and the saturating step helper for the PWM duty sequencer.
// The loop feature is enabled by defining PWM_SEQ_LOOP_EN.
package pwm_seq_pkg;

  localparam int DUTY_W_DEF = 16;
  localparam int DIV_W_DEF  = 16;
  // Helper works at a fixed maximum width so any DUTY_W up to this value can use it.
  localparam int SEQ_MAX_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } pwm_seq_state_t;

  // One step from cur toward tgt. Clamps at tgt so the ramp never overshoots.
  // Because tgt is a legal duty value, the ramp also never wraps at either end.
  // A step of zero jumps straight to tgt.
  function automatic logic [SEQ_MAX_W-1:0] sat_step(
    input logic [SEQ_MAX_W-1:0] cur,
    input logic [SEQ_MAX_W-1:0] tgt,
    input logic [SEQ_MAX_W-1:0] stp
  );
    logic [SEQ_MAX_W:0]   wide;
    logic [SEQ_MAX_W-1:0] res;
    wide = '0;
    res  = tgt;
    if (stp != '0 && cur != tgt) begin
      if (tgt > cur) begin
        wide = {1'b0, cur} + {1'b0, stp};
        res  = (wide > {1'b0, tgt}) ? tgt : wide[SEQ_MAX_W-1:0];
      end else begin
        wide = {1'b0, cur} - {1'b0, stp};
        // The borrow bit flags a step that would go below zero.
        res  = (wide[SEQ_MAX_W] || wide[SEQ_MAX_W-1:0] < tgt) ? tgt : wide[SEQ_MAX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_seq_ctrl_if.sv
// Request/status bundle between the register bank (master) and the duty sequencer (slave).
// loop_i is present only when PWM_SEQ_LOOP_EN is defined.
interface pwm_seq_ctrl_if
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
);

  logic              start_i;
  logic              abort_i;
  logic [DUTY_W-1:0] target_i;
  logic [DUTY_W-1:0] step_i;
  logic [DIV_W-1:0]  interval_i;
  logic              period_end_i;
`ifdef PWM_SEQ_LOOP_EN
  logic              loop_i;
`endif
  logic [DUTY_W-1:0] duty_o;
  logic              duty_load_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, abort_i, target_i, step_i, interval_i, period_end_i,
`ifdef PWM_SEQ_LOOP_EN
    output loop_i,
`endif
    input  duty_o, duty_load_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, target_i, step_i, interval_i, period_end_i,
`ifdef PWM_SEQ_LOOP_EN
    input  loop_i,
`endif
    output duty_o, duty_load_o, busy_o, done_o
  );

endinterface

// File: rtl/pwm_seq_tick.sv
// Interval counter: emits a one-cycle step_tick_o on the period_end_i pulse that
// completes the programmed number of PWM periods (an interval of 0 acts as 1).
module pwm_seq_tick
  import pwm_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             period_end_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] interval_i,
  output logic             step_tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] interval_eff;
  logic             last;

  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it unassigned and infers a latch.
    cnt_d        = cnt_q;
    interval_eff = (interval_i == '0) ? DIV_W'(1) : interval_i;
    last         = ({1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1}) >= {1'b0, interval_eff};
    step_tick_o  = period_end_i && !clear_i && last;
    if (clear_i) begin
      cnt_d = '0;
    end else if (period_end_i) begin
      cnt_d = last ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values, independent of block order.
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Duty-cycle sequencer: ramps duty_o toward a programmed target in paced, saturating steps.
// Define PWM_SEQ_LOOP_EN to add the ping-pong loop mode (loop_i).
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pwm_seq_ctrl_if.slave  bus
);

  pwm_seq_state_t    state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] target_q;
  logic [DUTY_W-1:0] step_q;
  logic [DIV_W-1:0]  interval_q;
  logic              load_q;
  logic              done_q;
`ifdef PWM_SEQ_LOOP_EN
  logic [DUTY_W-1:0] origin_q;
  logic              loop_q;
`endif

  logic [DUTY_W-1:0] next_duty_d;
  logic              step_tick;
  logic              tick_clear;

  // The counter only runs inside a ramp; any request restarts it, so a period_end
  // coinciding with start or abort is never counted.
  assign tick_clear = (state_q != RAMP) || bus.start_i || bus.abort_i;

  pwm_seq_tick #(.DIV_W(DIV_W)) u_tick (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .period_end_i (bus.period_end_i),
    .clear_i      (tick_clear),
    .interval_i   (interval_q),
    .step_tick_o  (step_tick)
  );

  assign next_duty_d = DUTY_W'(sat_step(SEQ_MAX_W'(duty_q), SEQ_MAX_W'(target_q), SEQ_MAX_W'(step_q)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PWM_SEQ_LOOP_EN
      origin_q   <= '0;
      loop_q     <= 1'b0;
`endif
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort_i) begin
        // Abort beats a simultaneous start; duty_o simply holds its value.
        state_q <= IDLE;
      end else if (bus.start_i) begin
        target_q   <= bus.target_i;
        step_q     <= bus.step_i;
        interval_q <= bus.interval_i;
`ifdef PWM_SEQ_LOOP_EN
        origin_q   <= duty_q;
        loop_q     <= bus.loop_i;
`endif
        if (bus.target_i == duty_q) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else begin
          state_q <= RAMP;
        end
      end else if (state_q == RAMP && step_tick) begin
        duty_q <= next_duty_d;
        load_q <= 1'b1;
        if (next_duty_d == target_q) begin
`ifdef PWM_SEQ_LOOP_EN
          if (loop_q) begin
            target_q <= origin_q;
            origin_q <= target_q;
          end else begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
`else
          state_q <= IDLE;
          done_q  <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.duty_o      = duty_q;
  assign bus.duty_load_o = load_q;
  assign bus.busy_o      = (state_q == RAMP);
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Self-checking bench for pwm_seq_ctrl: a scoreboard queue holds the expected duty
// sequence and a negedge monitor pops it on every duty_load_o pulse.
module tb_pwm_seq_ctrl;
  import pwm_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_seq_ctrl_if #(.DUTY_W(16), .DIV_W(16)) bus ();

  pwm_seq_ctrl #(.DUTY_W(16), .DIV_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] duty;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   load_cnt  = 0;
  int   done_cnt  = 0;
`ifdef PWM_SEQ_LOOP_EN
  logic loop_sel  = 1'b0;
`endif

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.done_o === 1'b1) done_cnt++;
      if (bus.duty_load_o === 1'b1) begin
        load_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_load: got duty=%0h done=%b, expected no load", bus.duty_o, bus.done_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.duty_o !== mon_e.duty || bus.done_o !== mon_e.done)
            $display("FAIL sb_load: got duty=%0h done=%b, expected duty=%0h done=%b",
                     bus.duty_o, bus.done_o, mon_e.duty, mon_e.done);
          else
            pass_cnt++;
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] d, input logic dn);
    exp_t t;
    t.duty = d;
    t.done = dn;
    exp_q.push_back(t);
  endtask

  task automatic drive_start(input logic [15:0] tgt, input logic [15:0] stp,
                             input logic [15:0] ivl, input logic pe);
    @(posedge clk); #1;
    bus.start_i      = 1'b1;
    bus.target_i     = tgt;
    bus.step_i       = stp;
    bus.interval_i   = ivl;
    bus.period_end_i = pe;
`ifdef PWM_SEQ_LOOP_EN
    bus.loop_i       = loop_sel;
`endif
    @(posedge clk); #1;
    bus.start_i      = 1'b0;
    bus.period_end_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic pulse_pe();
    @(posedge clk); #1;
    bus.period_end_i = 1'b1;
    @(posedge clk); #1;
    bus.period_end_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.abort_i      = 1'b0;
    bus.target_i     = '0;
    bus.step_i       = '0;
    bus.interval_i   = '0;
    bus.period_end_i = 1'b0;
`ifdef PWM_SEQ_LOOP_EN
    bus.loop_i       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.duty_o !== 16'h0) $display("FAIL reset_duty: got %0h expected 0", bus.duty_o); else pass_cnt++;
    total_cnt++; if (bus.duty_load_o !== 1'b0) $display("FAIL reset_load: got %b expected 0", bus.duty_load_o); else pass_cnt++;
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o); else pass_cnt++;
    total_cnt++; if (bus.done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done_o); else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_ramp_up();
    int l0 = load_cnt;
    int d0 = done_cnt;
    push_exp(16'd30, 1'b0); push_exp(16'd60, 1'b0); push_exp(16'd90, 1'b0); push_exp(16'd100, 1'b1);
    drive_start(16'd100, 16'd30, 16'd2, 1'b0);
    total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL up_busy_start: got %b expected 1", bus.busy_o); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      pulse_pe();
      total_cnt++;
      if (load_cnt - l0 !== k / 2) $display("FAIL up_pacing: after period %0d got %0d loads expected %0d", k, load_cnt - l0, k / 2);
      else pass_cnt++;
    end
    total_cnt++; if (bus.duty_o !== 16'd100) $display("FAIL up_final_duty: got %0d expected 100", bus.duty_o); else pass_cnt++;
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL up_busy_end: got %b expected 0", bus.busy_o); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL up_done_count: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL up_pending: got %0d expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_ramp_down();
    int l0 = load_cnt;
    int d0 = done_cnt;
    push_exp(16'd60, 1'b0); push_exp(16'd20, 1'b0); push_exp(16'd0, 1'b1);
    drive_start(16'd0, 16'd40, 16'd0, 1'b1);
    total_cnt++; if (load_cnt - l0 !== 0) $display("FAIL down_start_pe_counted: got %0d loads expected 0", load_cnt - l0); else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      pulse_pe();
      total_cnt++;
      if (load_cnt - l0 !== k) $display("FAIL down_pacing: after period %0d got %0d loads expected %0d", k, load_cnt - l0, k);
      else pass_cnt++;
    end
    total_cnt++; if (bus.duty_o !== 16'd0) $display("FAIL down_final_duty: got %0d expected 0", bus.duty_o); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL down_done_count: got %0d expected 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_jump();
    int l0 = load_cnt;
    int d0 = done_cnt;
    push_exp(16'hFFFF, 1'b1);
    drive_start(16'hFFFF, 16'd0, 16'd5, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      pulse_pe();
      total_cnt++;
      if (load_cnt - l0 !== ((k == 5) ? 1 : 0)) $display("FAIL jump_pacing: after period %0d got %0d loads", k, load_cnt - l0);
      else pass_cnt++;
    end
    total_cnt++; if (bus.duty_o !== 16'hFFFF) $display("FAIL jump_duty: got %0h expected ffff", bus.duty_o); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 1 || bus.busy_o !== 1'b0) $display("FAIL jump_done: got done=%0d busy=%b expected 1/0", done_cnt - d0, bus.busy_o); else pass_cnt++;
  endtask

  task automatic test_abort();
    int l0 = load_cnt;
    int d0 = done_cnt;
    push_exp(16'hEFFF, 1'b0); push_exp(16'hDFFF, 1'b0);
    drive_start(16'd0, 16'h1000, 16'd1, 1'b0);
    pulse_pe();
    pulse_pe();
    @(posedge clk); #1;
    bus.abort_i = 1'b1; bus.start_i = 1'b1; bus.target_i = 16'd5; bus.step_i = 16'd1;
    bus.interval_i = 16'd1; bus.period_end_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0; bus.start_i = 1'b0; bus.period_end_i = 1'b0;
    @(negedge clk); #1;
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy_o); else pass_cnt++;
    total_cnt++; if (bus.duty_o !== 16'hDFFF) $display("FAIL abort_duty: got %0h expected dfff", bus.duty_o); else pass_cnt++;
    repeat (3) pulse_pe();
    total_cnt++; if (load_cnt - l0 !== 2) $display("FAIL abort_loads: got %0d expected 2", load_cnt - l0); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 0) $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); else pass_cnt++;
    @(posedge clk); #1; bus.abort_i = 1'b1;
    @(posedge clk); #1; bus.abort_i = 1'b0;
    @(negedge clk); #1;
    total_cnt++; if (bus.duty_o !== 16'hDFFF || bus.busy_o !== 1'b0) $display("FAIL abort_idle: got duty=%0h busy=%b expected dfff/0", bus.duty_o, bus.busy_o); else pass_cnt++;
  endtask

  task automatic test_restart();
    int l0;
    int d0;
    push_exp(16'd0, 1'b1);
    drive_start(16'd0, 16'd0, 16'd1, 1'b0);
    pulse_pe();
    d0 = done_cnt;
    push_exp(16'd50, 1'b0);
    drive_start(16'd100, 16'd50, 16'd3, 1'b0);
    repeat (5) pulse_pe();
    total_cnt++; if (bus.duty_o !== 16'd50 || bus.busy_o !== 1'b1) $display("FAIL restart_mid: got duty=%0d busy=%b expected 50/1", bus.duty_o, bus.busy_o); else pass_cnt++;
    l0 = load_cnt;
    push_exp(16'd40, 1'b0); push_exp(16'd30, 1'b0); push_exp(16'd20, 1'b1);
    drive_start(16'd20, 16'd10, 16'd1, 1'b1);
    total_cnt++; if (load_cnt - l0 !== 0) $display("FAIL restart_start_pe: got %0d loads expected 0", load_cnt - l0); else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      pulse_pe();
      total_cnt++;
      if (load_cnt - l0 !== k) $display("FAIL restart_pacing: after period %0d got %0d loads expected %0d", k, load_cnt - l0, k);
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL restart_done_count: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (bus.duty_o !== 16'd20 || bus.busy_o !== 1'b0) $display("FAIL restart_end: got duty=%0d busy=%b expected 20/0", bus.duty_o, bus.busy_o); else pass_cnt++;
  endtask

  task automatic test_start_equal();
    int l0 = load_cnt;
    int d0 = done_cnt;
    drive_start(16'd20, 16'd5, 16'd1, 1'b0);
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL equal_done: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (load_cnt - l0 !== 0 || bus.busy_o !== 1'b0) $display("FAIL equal_idle: got loads=%0d busy=%b expected 0/0", load_cnt - l0, bus.busy_o); else pass_cnt++;
  endtask

`ifdef PWM_SEQ_LOOP_EN
  task automatic test_loop();
    int l0;
    int d0;
    loop_sel = 1'b0;
    push_exp(16'd0, 1'b1);
    drive_start(16'd0, 16'd0, 16'd1, 1'b0);
    pulse_pe();
    l0 = load_cnt;
    d0 = done_cnt;
    loop_sel = 1'b1;
    push_exp(16'd10, 1'b0); push_exp(16'd20, 1'b0); push_exp(16'd10, 1'b0);
    push_exp(16'd0, 1'b0);  push_exp(16'd10, 1'b0); push_exp(16'd20, 1'b0);
    drive_start(16'd20, 16'd10, 16'd1, 1'b0);
    loop_sel = 1'b0;
    repeat (6) pulse_pe();
    total_cnt++; if (load_cnt - l0 !== 6) $display("FAIL loop_loads: got %0d expected 6", load_cnt - l0); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 0 || bus.busy_o !== 1'b1) $display("FAIL loop_running: got done=%0d busy=%b expected 0/1", done_cnt - d0, bus.busy_o); else pass_cnt++;
    @(posedge clk); #1; bus.abort_i = 1'b1;
    @(posedge clk); #1; bus.abort_i = 1'b0;
    @(negedge clk); #1;
    total_cnt++; if (bus.busy_o !== 1'b0 || bus.duty_o !== 16'd20) $display("FAIL loop_abort: got busy=%b duty=%0d expected 0/20", bus.busy_o, bus.duty_o); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_jump();
    test_abort();
    test_restart();
    test_start_equal();
`ifdef PWM_SEQ_LOOP_EN
    test_loop();
`endif
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
